// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for the pong design.
// Produces the frame tick from a free-running divider on clk, runs the
// IDLE/SERVE/PLAY/POINT/OVER sequence, keeps both scores and gates the
// paddle/ball update strobes. Everything lives in the clk domain.
module pong_game_ctrl #(
  parameter int TICK_DIV    = 262144,
  parameter int SERVE_TICKS = 120,
  parameter int POINT_TICKS = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       frame_tick,
  output logic       paddle_en,
  output logic       ball_en,
  output logic       ball_rst,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic [1:0] winner
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX  = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int TIM_W = $clog2(TMAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [TIM_W-1:0] SERVE_LAST = TIM_W'(SERVE_TICKS - 1);
  localparam logic [TIM_W-1:0] POINT_LAST = TIM_W'(POINT_TICKS - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           st;
  logic [DIV_W-1:0] div_cnt;
  logic [TIM_W-1:0] timer;
  logic             start_q;
  logic             start_pulse;

  // Score increment that sticks at the winning score instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  // Free-running frame divider; frame_tick is registered off the wrap point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (div_cnt == DIV_LAST);
      div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Start edge detector; resets high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b1;
    else        start_q <= start;
  end

  assign start_pulse = start & ~start_q;

  // Game sequencer: state, phase timer, scores, serve direction and winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      timer     <= '0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      serve_dir <= 1'b0;
      winner    <= 2'd0;
    end else begin
      // Timer counts frame ticks; every state change below overrides this with a clear.
      if (frame_tick) timer <= timer + TIM_W'(1);
      case (st)
        S_IDLE, S_OVER: begin
          if (start_pulse) begin
            st      <= S_SERVE;
            timer   <= '0;
            score_l <= 4'd0;
            score_r <= 4'd0;
            winner  <= 2'd0;
          end
        end
        S_SERVE: begin
          if (frame_tick && timer == SERVE_LAST) begin
            st    <= S_PLAY;
            timer <= '0;
          end
        end
        S_PLAY: begin
          if (miss_left && miss_right) begin
            // Both sides missed together: replay the point toward the other side.
            serve_dir <= ~serve_dir;
            st        <= S_POINT;
            timer     <= '0;
          end else if (miss_left) begin
            score_r   <= sat_inc(score_r);
            serve_dir <= 1'b0;
            st        <= S_POINT;
            timer     <= '0;
          end else if (miss_right) begin
            score_l   <= sat_inc(score_l);
            serve_dir <= 1'b1;
            st        <= S_POINT;
            timer     <= '0;
          end
        end
        S_POINT: begin
          if (frame_tick && timer == POINT_LAST) begin
            timer <= '0;
            if (score_l == WIN || score_r == WIN) begin
              st     <= S_OVER;
              winner <= (score_l == WIN) ? 2'd1 : 2'd2;
            end else begin
              st <= S_SERVE;
            end
          end
        end
        default: begin
          st    <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign state     = st;
  assign paddle_en = frame_tick & ((st == S_SERVE) || (st == S_PLAY));
  assign ball_en   = frame_tick & (st == S_PLAY);
  assign ball_rst  = (st != S_PLAY);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a cycle-level game model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pong_game_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int SERVE_TICKS = 2;
  localparam int POINT_TICKS = 1;
  localparam int WIN_SCORE   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b1;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       frame_tick, paddle_en, ball_en, ball_rst, serve_dir;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // model state (game-level view)
  int m_cyc = 0;
  bit m_ft = 1'b0;
  bit m_sq = 1'b1;
  int m_st = 0;
  int m_ticks = 0;
  int m_sl = 0;
  int m_sr = 0;
  bit m_dir = 1'b0;
  int m_win = 0;

  pong_game_ctrl #(
    .TICK_DIV(TICK_DIV), .SERVE_TICKS(SERVE_TICKS),
    .POINT_TICKS(POINT_TICKS), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
    .frame_tick(frame_tick), .paddle_en(paddle_en), .ball_en(ball_en),
    .ball_rst(ball_rst), .serve_dir(serve_dir),
    .score_l(score_l), .score_r(score_r), .state(state), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int inc_sat(input int s);
    return (s + 1 > WIN_SCORE) ? WIN_SCORE : s + 1;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_ft = 1'b0; m_sq = 1'b1; m_st = 0; m_ticks = 0;
    m_sl = 0; m_sr = 0; m_dir = 1'b0; m_win = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    bit pft;
    bit sp;
    pft   = m_ft;
    sp    = start && !m_sq;
    m_sq  = start;
    m_cyc = m_cyc + 1;
    m_ft  = ((m_cyc % TICK_DIV) == 0);
    case (m_st)
      0, 4: if (sp) begin
        m_st = 1; m_ticks = 0; m_sl = 0; m_sr = 0; m_win = 0;
      end
      1: if (pft) begin
        m_ticks++;
        if (m_ticks == SERVE_TICKS) begin m_st = 2; m_ticks = 0; end
      end
      2: begin
        if (miss_left && miss_right) begin m_dir = !m_dir; m_st = 3; m_ticks = 0; end
        else if (miss_left) begin m_sr = inc_sat(m_sr); m_dir = 1'b0; m_st = 3; m_ticks = 0; end
        else if (miss_right) begin m_sl = inc_sat(m_sl); m_dir = 1'b1; m_st = 3; m_ticks = 0; end
      end
      3: if (pft) begin
        m_ticks++;
        if (m_ticks == POINT_TICKS) begin
          m_ticks = 0;
          if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin
            m_st = 4; m_win = (m_sl == WIN_SCORE) ? 1 : 2;
          end else m_st = 1;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("m_frame_tick", int'(frame_tick), int'(m_ft));
        chk("m_paddle_en", int'(paddle_en), int'(m_ft && (m_st == 1 || m_st == 2)));
        chk("m_ball_en", int'(ball_en), int'(m_ft && m_st == 2));
        chk("m_ball_rst", int'(ball_rst), int'(m_st != 2));
        chk("m_serve_dir", int'(serve_dir), int'(m_dir));
        chk("m_score_l", int'(score_l), m_sl);
        chk("m_score_r", int'(score_r), m_sr);
        chk("m_state", int'(state), m_st);
        chk("m_winner", int'(winner), m_win);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input string name);
    int n;
    n = 0;
    while (int'(state) != s && n < 100) begin step(); n++; end
    chk(name, int'(state), s);
  endtask

  // Stay in state s, counting frame ticks and paddle strobes until it is left.
  task automatic count_in(input int s, output int ticks, output int pe);
    int n;
    n = 0; ticks = 0; pe = 0;
    while (int'(state) == s && n < 100) begin
      if (frame_tick) ticks++;
      if (paddle_en) pe++;
      step();
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_frame_tick"}, int'(frame_tick), 0);
    chk({tag, "_paddle_en"}, int'(paddle_en), 0);
    chk({tag, "_ball_en"}, int'(ball_en), 0);
    chk({tag, "_ball_rst"}, int'(ball_rst), 1);
    chk({tag, "_serve_dir"}, int'(serve_dir), 0);
    chk({tag, "_score_l"}, int'(score_l), 0);
    chk({tag, "_score_r"}, int'(score_r), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_winner"}, int'(winner), 0);
  endtask

  initial begin
    int mask, pe_cnt, be_cnt, ticks, pe, n;
    // Reset with start held high.
    repeat (3) @(posedge clk);
    #3;
    chk_reset_vals("rst");
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Divider: 20 cycles, start still held so no transition.
    mask = 0; pe_cnt = 0; be_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (frame_tick) mask |= (1 << i);
      if (paddle_en) pe_cnt++;
      if (ball_en) be_cnt++;
    end
    chk("div_tick_cycles", mask, 32'h0011_1110);
    chk("div_paddle_en", pe_cnt, 0);
    chk("div_ball_en", be_cnt, 0);
    chk("div_state_idle", int'(state), 0);

    // Start and serve.
    start = 1'b0;
    step();
    chk("held_start_no_pulse", int'(state), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_to_serve", int'(state), 1);
    count_in(1, ticks, pe);
    chk("serve_ticks", ticks, 2);
    chk("serve_paddle_pulses", pe, 2);
    chk("serve_to_play", int'(state), 2);
    chk("play_ball_rst", int'(ball_rst), 0);

    // Scoring: left misses.
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    chk("missl_score_r", int'(score_r), 1);
    chk("missl_serve_dir", int'(serve_dir), 0);
    chk("missl_state", int'(state), 3);
    chk("missl_ball_rst", int'(ball_rst), 1);
    count_in(3, ticks, pe);
    chk("point_ticks", ticks, 1);
    chk("point_to_serve", int'(state), 1);
    wait_state(2, "reach_play_2");

    // Simultaneous miss: replay.
    miss_left = 1'b1; miss_right = 1'b1;
    step();
    miss_left = 1'b0; miss_right = 1'b0;
    chk("both_score_l", int'(score_l), 0);
    chk("both_score_r", int'(score_r), 1);
    chk("both_serve_dir", int'(serve_dir), 1);
    chk("both_state", int'(state), 3);
    wait_state(1, "both_to_serve");
    wait_state(2, "reach_play_3");

    // Two right misses end the game.
    miss_right = 1'b1;
    step();
    miss_right = 1'b0;
    chk("missr1_score_l", int'(score_l), 1);
    chk("missr1_serve_dir", int'(serve_dir), 1);
    wait_state(1, "missr1_to_serve");
    wait_state(2, "reach_play_4");
    miss_right = 1'b1;
    step();
    miss_right = 1'b0;
    chk("missr2_score_l", int'(score_l), 2);
    chk("missr2_state", int'(state), 3);
    wait_state(4, "game_over");
    chk("over_winner", int'(winner), 1);

    // Misses in OVER are ignored.
    miss_left = 1'b1; miss_right = 1'b1;
    repeat (3) step();
    miss_left = 1'b0; miss_right = 1'b0;
    chk("over_ign_score_l", int'(score_l), 2);
    chk("over_ign_score_r", int'(score_r), 1);
    chk("over_ign_state", int'(state), 4);
    chk("over_ign_winner", int'(winner), 1);

    // Restart from OVER.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_score_l", int'(score_l), 0);
    chk("restart_score_r", int'(score_r), 0);
    chk("restart_winner", int'(winner), 0);
    chk("restart_state", int'(state), 1);
    wait_state(2, "reach_play_5");

    // Miss in the same cycle as a frame tick: ball_en still fires.
    n = 0;
    while (!frame_tick && n < 20) begin step(); n++; end
    chk("tick_in_play", int'(frame_tick), 1);
    miss_left = 1'b1;
    chk("tick_miss_ball_en", int'(ball_en), 1);
    step();
    miss_left = 1'b0;
    chk("tick_miss_state", int'(state), 3);
    chk("tick_miss_score_r", int'(score_r), 1);
    wait_state(2, "reach_play_6");

    // Asynchronous reset mid-PLAY with a miss and start pending.
    #2;
    miss_right = 1'b1;
    start = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #3;
    miss_right = 1'b0;
    rst_n = 1'b1;
    repeat (6) step();
    chk("postrst_state", int'(state), 0);
    chk("postrst_score_l", int'(score_l), 0);
    start = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the pong design. Derives the frame tick from `clk` with a synchronous divider, so no ripple-clock domains are needed. Runs the serve / play / point / game-over state machine and keeps both scores. Gates the paddle and ball update enables consumed by the paddle and ball blocks, which all run on `clk`.

## Interface
- `TICK_DIV`, 262144: `clk` cycles per frame tick; must be ≥ 2.
- `SERVE_TICKS`, 120: frame ticks spent in SERVE before PLAY; must be ≥ 1.
- `POINT_TICKS`, 60: frame ticks spent in POINT after a miss; must be ≥ 1.
- `WIN_SCORE`, 7: score that ends the game; must be 1..15.

Ports:
- `clk` input 1: single system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: start button, active high, synchronous to `clk`.
- `miss_left` input 1: one-cycle pulse from ball logic when the ball passes the left paddle.
- `miss_right` input 1: one-cycle pulse when the ball passes the right paddle.
- `frame_tick` output 1: one-cycle pulse every `TICK_DIV` cycles.
- `paddle_en` output 1: paddle position update strobe.
- `ball_en` output 1: ball position update strobe.
- `ball_rst` output 1: holds the ball at center while high.
- `serve_dir` output 1: 0 = serve toward left, 1 = serve toward right.
- `score_l` output 4: left player score.
- `score_r` output 4: right player score.
- `state` output 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- `winner` output 2: 0 none, 1 left, 2 right.

## Operation
- Tick divider:
  - Counter runs 0..`TICK_DIV`-1 and wraps to 0.
  - `frame_tick` is registered and high in the cycle after the counter holds `TICK_DIV`-1.
  - The divider runs freely in every state.
- Start detection:
  - `start_q` is a registered copy of `start`, reset to 1.
  - `start_pulse` = `start` & ~`start_q`.
  - Holding `start` through reset release produces no pulse.
- Phase timer:
  - Cleared on every state change.
  - Increments on each `frame_tick`.
- State transitions:
  - IDLE: `start_pulse` → SERVE. Scores and `winner` are cleared to 0 on this transition.
  - SERVE: `frame_tick` with timer == `SERVE_TICKS`-1 → PLAY.
  - PLAY, `miss_left` only: `score_r`+1, `serve_dir`=0, → POINT.
  - PLAY, `miss_right` only: `score_l`+1, `serve_dir`=1, → POINT.
  - PLAY, both misses in the same cycle: no score change, `serve_dir` toggles, → POINT (replay).
  - POINT: `frame_tick` with timer == `POINT_TICKS`-1 → OVER if either score == `WIN_SCORE`, else SERVE.
  - OVER: `winner` is set on entry and held. `start_pulse` → SERVE with scores and `winner` cleared.
- `miss_*` inputs are ignored outside PLAY.
- `start_pulse` is ignored outside IDLE and OVER.
- Scores saturate at `WIN_SCORE` and never wrap.
- Output gating:
  - `paddle_en` = `frame_tick` & (state ∈ {SERVE, PLAY}).
  - `ball_en` = `frame_tick` & (state == PLAY).
  - `ball_rst` = state ≠ PLAY.
  - All three are derived from registered signals only.

## Timing
- Reset values:
  - `state`=IDLE, divider 0, timer 0.
  - `frame_tick`=0, `paddle_en`=0, `ball_en`=0.
  - `ball_rst`=1, `serve_dir`=0.
  - `score_l`=0, `score_r`=0, `winner`=0.
- First `frame_tick` after reset release: high in cycle `TICK_DIV` (cycle 1 = first clock edge after release).
- Miss response: miss sampled at edge N → score, `serve_dir` and `state`=POINT visible after edge N; `ball_rst` high from then on.
- SERVE duration: exactly `SERVE_TICKS` frame ticks. `paddle_en` pulses `SERVE_TICKS` times; the last pulse occurs while still in SERVE.
- POINT duration: exactly `POINT_TICKS` frame ticks.
- A miss arriving in the same cycle as `frame_tick` in PLAY: that tick's `ball_en` still fires, and the state goes to POINT at the next edge.
- Reset mid-game: asynchronous return to all reset values. No pending miss or start is remembered.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `SERVE_TICKS`=2, `POINT_TICKS`=1, `WIN_SCORE`=2.

- Divider:
  - Stimulus: release reset, run 20 cycles.
  - Required: `frame_tick` high in cycles 4, 8, 12, 16, 20 only; `paddle_en`/`ball_en` never high; `state`=0.
- Start and serve:
  - Stimulus: hold `start`=1 through reset release.
  - Required: no transition.
  - Stimulus: drop `start`, then pulse it.
  - Required: SERVE for exactly 2 frame ticks with 2 `paddle_en` pulses, then `state`=2 and `ball_rst`=0.
- Scoring:
  - Stimulus: in PLAY, pulse `miss_left`.
  - Required: next cycle `score_r`=1, `serve_dir`=0, `state`=3; back to SERVE after 1 frame tick.
- Simultaneous miss:
  - Stimulus: in PLAY, assert `miss_left` and `miss_right` together.
  - Required: scores unchanged, `serve_dir` toggled, `state`=3.
- Game over and restart:
  - Stimulus: two `miss_right` in PLAY.
  - Required: `score_l`=2, then `state`=4, `winner`=1.
  - Stimulus: further misses.
  - Required: ignored.
  - Stimulus: pulse `start`.
  - Required: scores=0, `winner`=0, `state`=1.
- Reset mid-PLAY:
  - Stimulus: drop `rst_n` asynchronously between clock edges with `score_r`=1.
  - Required: all outputs immediately at reset values.
